// File: rtl/dequant_pkg.sv
// Shared definitions for the dequantization block: FSM state encoding,
// default scaling constants and the product-width helper.
package dequant_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SUB  = 3'd1,
    S_MUL  = 3'd2,
    S_RND  = 3'd3,
    S_HOLD = 3'd4
  } state_e;

  localparam int          DEF_IN_W       = 9;
  localparam int          DEF_OUT_W      = 64;
  localparam int          DEF_ZERO_POINT = 0;
  localparam logic [31:0] DEF_MULT       = 32'd1073741824;  // 0.5 in Q31
  localparam int          DEF_RSHIFT     = 22;              // with DEF_MULT: exact x256

  // (IN_W+1)-bit difference times a 33-bit non-negative multiplier.
  function automatic int prod_w(input int in_w);
    return in_w + 33;
  endfunction

endpackage

// File: rtl/dequant_if.sv
// Valid/ready handshake bundle between the feature-map buffer, the
// dequantizer and the downstream accumulator.
interface dequant_if
  import dequant_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) ();

  logic signed [IN_W-1:0]  num_quant;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [OUT_W-1:0] num_deq;
  logic                    sig_ok;
  logic                    out_ready;
  logic                    sat;

  // Producer/consumer side.
  modport master (
    output num_quant, in_valid, out_ready,
    input  in_ready, num_deq, sig_ok, sat
  );

  // Dequantizer side.
  modport slave (
    input  num_quant, in_valid, out_ready,
    output in_ready, num_deq, sig_ok, sat
  );

endinterface

// File: rtl/round_shift.sv
// Combinational arithmetic right shift with rounding half away from zero.
// One guard bit keeps the rounding add from overflowing.
module round_shift #(
  parameter int W     = 42,
  parameter int SHIFT = 22
) (
  input  logic signed [W-1:0] x_i,
  output logic signed [W-1:0] y_o
);

  generate
    if (SHIFT == 0) begin : g_pass
      assign y_o = x_i;
    end else begin : g_round
      localparam logic signed [W:0] HALF    = (W+1)'(1) << (SHIFT - 1);
      localparam logic signed [W:0] HALF_M1 = HALF - (W+1)'(1);

      logic signed [W:0] x_ext;
      logic signed [W:0] sum;

      assign x_ext = (W+1)'(x_i);
      // Negative inputs add one less so that ties move away from zero.
      assign sum   = x_i[W-1] ? (x_ext + HALF_M1) : (x_ext + HALF);
      assign y_o   = W'(sum >>> SHIFT);
    end
  endgenerate

endmodule

// File: rtl/dequantization.sv
// Dequantizer: num_deq = round((num_quant - ZERO_POINT) * MULT / 2^RSHIFT),
// ties away from zero, through a SUB -> MUL -> RND -> HOLD pipeline with a
// single operation in flight.
// Build option: define DEQUANT_SAT_EN to clamp results that do not fit in
// OUT_W bits (and flag them on sat); otherwise results wrap and sat is 0.
module dequantization
  import dequant_pkg::*;
#(
  parameter int                     IN_W       = DEF_IN_W,
  parameter int                     OUT_W      = DEF_OUT_W,
  parameter logic signed [IN_W-1:0] ZERO_POINT = IN_W'(DEF_ZERO_POINT),
  parameter logic [31:0]            MULT       = DEF_MULT,
  parameter int                     RSHIFT     = DEF_RSHIFT
) (
  input  logic     clk,
  input  logic     rst,
  dequant_if.slave dq
);

  localparam int PW = prod_w(IN_W);

  state_e                  state_q;
  logic signed [IN_W-1:0]  nq_q;
  logic signed [IN_W:0]    diff_q;
  logic signed [PW-1:0]    prod_q;
  logic signed [OUT_W-1:0] num_deq_q;
  logic                    sig_ok_q;
  logic                    sat_q;

  logic signed [PW-1:0]    r;
  logic signed [OUT_W-1:0] num_deq_d;
  logic                    sat_d;

  round_shift #(.W(PW), .SHIFT(RSHIFT)) u_round_shift (
    .x_i (prod_q),
    .y_o (r)
  );

`ifdef DEQUANT_SAT_EN
  localparam int XW = (OUT_W > PW) ? OUT_W : PW;
  localparam logic signed [XW-1:0] MAXV = XW'({1'b0, {(OUT_W-1){1'b1}}});
  localparam logic signed [XW-1:0] MINV = XW'($signed({1'b1, {(OUT_W-1){1'b0}}}));

  logic signed [XW-1:0] r_x;
  assign r_x = XW'(r);

  // Clamp the rounded value into the signed OUT_W range.
  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    num_deq_d = OUT_W'(r);
    sat_d     = 1'b0;
    if (r_x > MAXV) begin
      num_deq_d = {1'b0, {(OUT_W-1){1'b1}}};
      sat_d     = 1'b1;
    end else if (r_x < MINV) begin
      num_deq_d = {1'b1, {(OUT_W-1){1'b0}}};
      sat_d     = 1'b1;
    end
  end
`else
  // Keep the low OUT_W bits (sign-extends when OUT_W is wider than r).
  assign num_deq_d = OUT_W'(r);
  assign sat_d     = 1'b0;
`endif

  // Control FSM and datapath registers; reset drops any in-flight operation.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      nq_q      <= '0;
      diff_q    <= '0;
      prod_q    <= '0;
      num_deq_q <= '0;
      sig_ok_q  <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (dq.in_valid) begin
            nq_q    <= dq.num_quant;
            state_q <= S_SUB;
          end
        end
        S_SUB: begin
          diff_q  <= $signed({nq_q[IN_W-1], nq_q}) -
                     $signed({ZERO_POINT[IN_W-1], ZERO_POINT});
          state_q <= S_MUL;
        end
        S_MUL: begin
          prod_q  <= PW'(diff_q) * PW'($signed({1'b0, MULT}));
          state_q <= S_RND;
        end
        S_RND: begin
          num_deq_q <= num_deq_d;
          sat_q     <= sat_d;
          sig_ok_q  <= 1'b1;
          state_q   <= S_HOLD;
        end
        S_HOLD: begin
          if (dq.out_ready) begin
            sig_ok_q <= 1'b0;
            sat_q    <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dq.in_ready = (state_q == S_IDLE);
  assign dq.num_deq  = num_deq_q;
  assign dq.sig_ok   = sig_ok_q;
  assign dq.sat      = sat_q;

endmodule

// File: tb/tb_dequantization.sv
// Testbench for dequantization: six differently parameterised instances run
// in lockstep from one shared stimulus stream and are compared against an
// arithmetic reference model plus a table of hand-derived results.
// Honours DEQUANT_SAT_EN for the 16-bit-output instance.
module tb_dequantization;
  import dequant_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic signed [8:0] nq = '0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

`ifdef DEQUANT_SAT_EN
  localparam longint D_255  = 32767;
  localparam longint D_M256 = -32768;
`else
  localparam longint D_255  = -256;
  localparam longint D_M256 = 0;
`endif

  typedef struct {
    int     q;
    int     stall;
    longint a;   // defaults
    longint b;   // MULT=3, RSHIFT=1
    longint c;   // ZERO_POINT=-10
    longint d;   // OUT_W=16
  } vec_t;

  dequant_if #(.IN_W(9), .OUT_W(64)) if_a ();
  dequant_if #(.IN_W(9), .OUT_W(64)) if_b ();
  dequant_if #(.IN_W(9), .OUT_W(64)) if_c ();
  dequant_if #(.IN_W(9), .OUT_W(16)) if_d ();
  dequant_if #(.IN_W(9), .OUT_W(64)) if_e ();
  dequant_if #(.IN_W(9), .OUT_W(64)) if_f ();

  assign if_a.num_quant = nq; assign if_a.in_valid = in_valid; assign if_a.out_ready = out_ready;
  assign if_b.num_quant = nq; assign if_b.in_valid = in_valid; assign if_b.out_ready = out_ready;
  assign if_c.num_quant = nq; assign if_c.in_valid = in_valid; assign if_c.out_ready = out_ready;
  assign if_d.num_quant = nq; assign if_d.in_valid = in_valid; assign if_d.out_ready = out_ready;
  assign if_e.num_quant = nq; assign if_e.in_valid = in_valid; assign if_e.out_ready = out_ready;
  assign if_f.num_quant = nq; assign if_f.in_valid = in_valid; assign if_f.out_ready = out_ready;

  dequantization #(.IN_W(9), .OUT_W(64)) u_a (.clk(clk), .rst(rst), .dq(if_a.slave));
  dequantization #(.IN_W(9), .OUT_W(64), .MULT(32'd3), .RSHIFT(1))
    u_b (.clk(clk), .rst(rst), .dq(if_b.slave));
  dequantization #(.IN_W(9), .OUT_W(64), .ZERO_POINT(-9'sd10))
    u_c (.clk(clk), .rst(rst), .dq(if_c.slave));
  dequantization #(.IN_W(9), .OUT_W(16)) u_d (.clk(clk), .rst(rst), .dq(if_d.slave));
  dequantization #(.IN_W(9), .OUT_W(64), .ZERO_POINT(9'sd37), .MULT(32'hDEADBEEF), .RSHIFT(40))
    u_e (.clk(clk), .rst(rst), .dq(if_e.slave));
  dequantization #(.IN_W(9), .OUT_W(64), .ZERO_POINT(9'sh100), .MULT(32'hFFFFFFFF), .RSHIFT(0))
    u_f (.clk(clk), .rst(rst), .dq(if_f.slave));

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Exact scaled value, rounded on its magnitude, then fitted to ow bits.
  function automatic longint model(input int q, input int zp, input longint mult,
                                   input int sh, input int ow, output bit sat);
    longint p, mag, r, lim;
    p   = longint'(q - zp) * mult;
    mag = (p < 0) ? -p : p;
    if (sh == 0) r = p;
    else begin
      mag = (mag + (longint'(1) << (sh - 1))) / (longint'(1) << sh);
      r   = (p < 0) ? -mag : mag;
    end
    sat = 1'b0;
    if (ow < 64) begin
      lim = longint'(1) << (ow - 1);
`ifdef DEQUANT_SAT_EN
      if (r > lim - 1) begin r = lim - 1; sat = 1'b1; end
      else if (r < -lim) begin r = -lim; sat = 1'b1; end
`else
      r = (r << (64 - ow)) >>> (64 - ow);
`endif
    end
    return r;
  endfunction

  task automatic check_results(input int q);
    bit s;
    longint e;
    e = model(q, 0, 64'd1073741824, 22, 64, s);
    check($sformatf("A q=%0d deq", q), $signed(if_a.num_deq), e);
    check($sformatf("A q=%0d sat", q), if_a.sat, s);
    e = model(q, 0, 64'd3, 1, 64, s);
    check($sformatf("B q=%0d deq", q), $signed(if_b.num_deq), e);
    e = model(q, -10, 64'd1073741824, 22, 64, s);
    check($sformatf("C q=%0d deq", q), $signed(if_c.num_deq), e);
    e = model(q, 0, 64'd1073741824, 22, 16, s);
    check($sformatf("D q=%0d deq", q), $signed(if_d.num_deq), e);
    check($sformatf("D q=%0d sat", q), if_d.sat, s);
    e = model(q, 37, 64'hDEADBEEF, 40, 64, s);
    check($sformatf("E q=%0d deq", q), $signed(if_e.num_deq), e);
    e = model(q, -256, 64'hFFFFFFFF, 0, 64, s);
    check($sformatf("F q=%0d deq", q), $signed(if_f.num_deq), e);
    check($sformatf("F q=%0d sat", q), if_f.sat, s);
  endtask

  // One transaction: accept, measure latency, optionally stall the consumer
  // (injecting a stray in_valid with 99), then release and check the return.
  task automatic run_op(input int q, input int stall);
    int edges;
    @(negedge clk);
    check("in_ready idle", if_a.in_ready, 1);
    nq = 9'(q);
    in_valid = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    in_valid = 1'b0;
    nq = '0;
    while (if_a.sig_ok !== 1'b1 && edges < 12) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check($sformatf("latency q=%0d", q), edges, 4);
    check("sig_ok D", if_d.sig_ok, 1);
    check_results(q);
    for (int i = 0; i < stall; i++) begin
      check("stall in_ready", if_a.in_ready, 0);
      check("stall sig_ok", if_a.sig_ok, 1);
      if (i == 2) begin
        in_valid = 1'b1;
        nq = 9'sd99;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      check_results(q);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("sig_ok drop", if_a.sig_ok, 0);
    check("sat drop D", if_d.sat, 0);
    check("in_ready back", if_a.in_ready, 1);
  endtask

  initial begin
    vec_t vecs[12];
    int   q, stall, seen;

    vecs[0]  = '{5,    0, 1280,   8,    3840,   1280};
    vecs[1]  = '{-256, 0, -65536, -384, -62976, D_M256};
    vecs[2]  = '{255,  0, 65280,  383,  67840,  D_255};
    vecs[3]  = '{0,    0, 0,      0,    2560,   0};
    vecs[4]  = '{-5,   0, -1280,  -8,   1280,   -1280};
    vecs[5]  = '{4,    0, 1024,   6,    3584,   1024};
    vecs[6]  = '{-3,   0, -768,   -5,   1792,   -768};
    vecs[7]  = '{-10,  0, -2560,  -15,  0,      -2560};
    vecs[8]  = '{20,   6, 5120,   30,   7680,   5120};
    vecs[9]  = '{1,    0, 256,    2,    2816,   256};
    vecs[10] = '{-1,   1, -256,   -2,   2304,   -256};
    vecs[11] = '{127,  3, 32512,  191,  35072,  32512};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst deq A", $signed(if_a.num_deq), 0);
    check("rst sig_ok A", if_a.sig_ok, 0);
    check("rst sat D", if_d.sat, 0);
    check("rst in_ready A", if_a.in_ready, 1);
    rst = 1'b0;

    // Directed table
    foreach (vecs[i]) begin
      run_op(vecs[i].q, vecs[i].stall);
      check($sformatf("tbl A q=%0d", vecs[i].q), $signed(if_a.num_deq), vecs[i].a);
      check($sformatf("tbl B q=%0d", vecs[i].q), $signed(if_b.num_deq), vecs[i].b);
      check($sformatf("tbl C q=%0d", vecs[i].q), $signed(if_c.num_deq), vecs[i].c);
      check($sformatf("tbl D q=%0d", vecs[i].q), $signed(if_d.num_deq), vecs[i].d);
    end
`ifdef DEQUANT_SAT_EN
    run_op(255, 2);
    check("sat flag held D", if_d.sat, 0);
`endif

    // Asynchronous reset while the operation sits in MUL
    @(negedge clk);
    nq = 9'sd50;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst deq A", $signed(if_a.num_deq), 0);
    check("arst deq D", $signed(if_d.num_deq), 0);
    check("arst sig_ok A", if_a.sig_ok, 0);
    check("arst in_ready A", if_a.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (if_a.sig_ok === 1'b1) seen++;
    end
    check("arst discarded", seen, 0);

    // Randomised operations
    for (int n = 0; n < 40; n++) begin
      q     = int'($urandom_range(0, 511)) - 256;
      stall = int'($urandom_range(0, 3));
      run_op(q, stall);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
